// File: rtl/avg_pkg.sv
// avg_pkg: shared AVG opcodes, fetch state encoding and return-stack default depth
package avg_pkg;
  localparam logic [2:0] OP_VCTR  = 3'b000;
  localparam logic [2:0] OP_HALT  = 3'b001;
  localparam logic [2:0] OP_SVEC  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_CNTR  = 3'b100;
  localparam logic [2:0] OP_JSR   = 3'b101;
  localparam logic [2:0] OP_RTS   = 3'b110;
  localparam logic [2:0] OP_JMP   = 3'b111;
  localparam int DEF_STACK_DEPTH = 4;
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, CAP_LO, PRESENT} fetch_state_t;
endpackage

// File: rtl/avg_ret_stack.sv
// avg_ret_stack: LIFO of subroutine return addresses; push when full and pop when empty are dropped
module avg_ret_stack
  import avg_pkg::*;
#(
  parameter int DEPTH = DEF_STACK_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [AW:0] sp;
  logic [AW:0] sp_m1;
  logic [15:0] mem [DEPTH];
  assign sp_m1 = sp - ONE;
  assign full  = sp == (AW+1)'(DEPTH);
  assign empty = sp == '0;
  assign dout  = mem[sp_m1[AW-1:0]];
  // stack pointer: cleared on reset or frame start, moves on accepted push/pop
  always_ff @(posedge clk)
    if (!rst_n || clear) sp <= '0;
    else if (push && !full) sp <= sp + ONE;
    else if (pop && !empty) sp <= sp_m1;
  // entry storage needs no reset; only slots below sp are ever read meaningfully
  always_ff @(posedge clk)
    if (push && !full) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/avg_fetch.sv
// avg_fetch: AVG instruction fetch and program flow; AVG_SHORT_FETCH_EN skips the second read for one-word opcodes
module avg_fetch
  import avg_pkg::*;
#(
  parameter int          STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [15:0] START_ADDR  = 16'h2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [15:0] start_addr,
  output logic        mem_rd,
  output logic [14:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [2:0]  dcd_pcOffset,
  input  logic        dcd_jmp,
  input  logic        dcd_jsr,
  input  logic        dcd_ret,
  input  logic        dcd_halt,
  input  logic [15:0] dcd_jumpAddr,
  output logic        halted,
  output logic        stack_err,
  output logic [15:0] pc
);
  fetch_state_t state, state_n;
  logic [15:0] pc_n, step, top;
  logic        push, pop, clear, err_set, full, empty, short_f;
`ifdef AVG_SHORT_FETCH_EN
  assign short_f = mem_data[15:13] != OP_VCTR;
`else
  assign short_f = 1'b0;
`endif
  assign step       = pc + {12'b0, dcd_pcOffset, 1'b0};
  assign mem_rd     = state == RD_HI || (state == RD_LO && !short_f);
  assign mem_addr   = state == RD_HI ? pc[15:1] : state == RD_LO ? pc[15:1] + 15'd1 : '0;
  assign inst_valid = state == PRESENT;
  assign halted     = state == IDLE;
  avg_ret_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (step),
    .dout  (top),
    .full  (full),
    .empty (empty)
  );
  // sequencing of the two word reads and the flow-control decision on acceptance
  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_n = RD_HI;
        pc_n    = start_addr;
        clear   = 1'b1;
      end
      RD_HI:  state_n = RD_LO;
      RD_LO:  state_n = short_f ? PRESENT : CAP_LO;
      CAP_LO: state_n = PRESENT;
      PRESENT: if (inst_ready) begin
        state_n = RD_HI;
        if (dcd_halt) begin
          state_n = IDLE;
          pc_n    = step;
        end else if (dcd_ret) begin
          err_set = empty;
          pop     = !empty;
          pc_n    = empty ? pc : top;
          state_n = empty ? IDLE : RD_HI;
        end else if (dcd_jmp && dcd_jsr) begin
          push    = !full;
          err_set = full;
          pc_n    = dcd_jumpAddr;
        end else if (dcd_jmp) pc_n = dcd_jumpAddr;
        else pc_n = step;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, pc, sticky error and the assembled instruction halves
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= START_ADDR;
      inst      <= '0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      stack_err <= clear ? 1'b0 : stack_err | err_set;
      if (state == RD_LO) inst[31:16] <= mem_data;
      if (state == RD_LO && short_f) inst[15:0] <= '0;
      if (state == CAP_LO) inst[15:0] <= mem_data;
    end
endmodule

// File: doc/avg_fetch.md
Name: avg_fetch

Overview:
- Instruction fetch and program-flow stage of the AVG (analog vector generator); sits directly upstream of the AVG instruction decoder.
- Reads 16-bit words from vector memory, assembles a 32-bit instruction word (first word in [31:16], second in [15:0]) and presents it with valid/ready.
- Consumes the decoder's flow-control results (pcOffset, jmp, jsr, ret, halt, jumpAddr) to update the PC and the subroutine return stack.

Parameters:
- STACK_DEPTH, 4, number of return-stack entries (power of 2, ≥2).
- START_ADDR, 16'h2000, byte address loaded into the PC on reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- go  in  1  one-cycle pulse; starts a frame from start_addr when halted
- start_addr  in  16  byte address of the frame's first instruction
- mem_rd  out  1  vector-memory read strobe
- mem_addr  out  15  word address (pc[15:1])
- mem_data  in  16  read data, valid exactly 1 cycle after mem_rd
- inst  out  32  assembled instruction to the decoder
- inst_valid  out  1  inst is stable and valid
- inst_ready  in  1  downstream accepts inst this cycle
- dcd_pcOffset  in  3  decoder instruction length, in words
- dcd_jmp, dcd_jsr, dcd_ret, dcd_halt  in  1 each  decoder flow flags for the current inst
- dcd_jumpAddr  in  16  decoder jump target, byte address
- halted  out  1  fetch is idle
- stack_err  out  1  sticky flag for return-stack overflow or underflow
- pc  out  16  current byte PC, for debug

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, pc=START_ADDR, stack pointer=0, inst=0, inst_valid=0, mem_rd=0, mem_addr=0, halted=1, stack_err=0.
- States: IDLE, RD_HI, RD_LO, CAP_LO, PRESENT.
- IDLE:
  - halted=1.
  - On go: pc<=start_addr, sp<=0, stack_err<=0, go to RD_HI.
  - go in any state other than IDLE is ignored.
- RD_HI: mem_rd=1, mem_addr=pc[15:1], then RD_LO.
- RD_LO: latch mem_data into inst[31:16]; mem_rd=1, mem_addr=pc[15:1]+1 (15-bit wrap); then CAP_LO.
- CAP_LO: latch mem_data into inst[15:0]; then PRESENT.
- PRESENT:
  - inst_valid=1; inst held stable until accepted.
  - The decoder's dcd_* inputs are combinational from inst and are sampled only when inst_valid && inst_ready.
- Latency: go to first inst_valid is 4 cycles. Acceptance to next inst_valid is 4 cycles.
- Priority on acceptance (highest first):
  - dcd_halt: go to IDLE; pc += 2*dcd_pcOffset.
  - dcd_ret:
    - Stack empty: stack_err<=1, go to IDLE.
    - Otherwise: pc <= pop; go to RD_HI.
  - dcd_jmp with dcd_jsr:
    - Stack full: stack_err<=1, no push, pc <= dcd_jumpAddr anyway.
    - Otherwise: push pc + 2*dcd_pcOffset, pc <= dcd_jumpAddr.
    - Go to RD_HI.
  - dcd_jmp alone: pc <= dcd_jumpAddr; go to RD_HI.
  - Otherwise: pc <= pc + 2*dcd_pcOffset (16-bit wrap); go to RD_HI.
- inst_valid drops the cycle after acceptance.
- Return stack is LIFO, STACK_DEPTH entries of 16 bits.
- stack_err is sticky until the next accepted go or reset.
- Reset mid-fetch: synchronous reset dominates every state. Any outstanding memory read data is discarded.
- inst_ready while not in PRESENT has no effect.

Optional Feature:
- Macro: AVG_SHORT_FETCH_EN.
- When defined:
  - In RD_LO, if mem_data[15:13] != OP_VCTR, skip the second read.
  - Set inst[15:0]=16'h0000 and go directly to PRESENT (mem_rd=0 that cycle).
  - One-word instructions then present 3 cycles after go or acceptance.
- When undefined: always two reads, with the timing above.

Decomposition:
- Shared package avg_pkg: opcode constants OP_VCTR=3'b000, OP_HALT=3'b001, OP_SVEC=3'b010, OP_STORE=3'b011, OP_CNTR=3'b100, OP_JSR=3'b101, OP_RTS=3'b110, OP_JMP=3'b111.
- Also in avg_pkg: fetch state enum typedef and the STACK_DEPTH default.
- One sub-module, avg_ret_stack:
  - push, pop, din, dout, full, empty, synchronous active-low reset, clear input.
  - Simultaneous push and pop never occur.

Test Plan:
- Reset then go with start_addr=16'h2000, memory words 0x0000@0x1000 and 0x1234@0x1001, inst_ready=1 → mem_addr 0x1000 then 0x1001; inst=32'h0000_1234 valid 4 cycles after go. With pcOffset=2, next fetch is at word 0x1002.
- Straight-line SVEC (pcOffset=1) at pc 0x2000 → next pc=0x2002.
- JSR with jumpAddr=0x2400 at pc 0x2010, pcOffset=1 → pc=0x2400; stack top=0x2012. A following RTS returns pc to 0x2012.
- Five nested JSRs with STACK_DEPTH=4 → stack_err=1 after the 5th, and pc still jumps. RTS on an empty stack → stack_err=1, halted=1.
- HALT accepted → halted=1 and mem_rd stays 0. go pulsed while running → ignored. Reset asserted during RD_LO → all outputs return to their reset values on the next edge.
- Hold inst_ready=0 for 10 cycles in PRESENT → inst stable, no mem_rd. With AVG_SHORT_FETCH_EN, a CNTR word 0x8000 presents inst=32'h8000_0000 3 cycles after go.
